// File: rtl/cdc_2phase_receiver_if.sv
// Receiver-side bundle of a 2-phase toggle link plus its local valid/ready output.
// master = remote sender and local consumer; slave = the receiver block.
interface cdc_2phase_receiver_if #(
  parameter int unsigned WORD_WIDTH = 8
);
  logic                  req_toggle;
  logic [WORD_WIDTH-1:0] data_in;
  logic                  ack_toggle;
  logic                  valid_out;
  logic                  ready_in;
  logic [WORD_WIDTH-1:0] data_out;

  modport master (
    output req_toggle, data_in, ready_in,
    input  ack_toggle, valid_out, data_out
  );

  modport slave (
    input  req_toggle, data_in, ready_in,
    output ack_toggle, valid_out, data_out
  );
endinterface

// File: rtl/cdc_2phase_receiver.sv
// Receiving end of a 2-phase toggle handshake: synchronise the request level,
// capture the word on a level change, offer it via valid/ready, toggle ack on accept.
module cdc_2phase_receiver #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    clock,
  input logic                    clear,
  cdc_2phase_receiver_if.slave   link
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    req_sync;
  logic                    req_seen_q, req_seen_d;
  logic                    ack_q, ack_d;
  logic                    valid_q, valid_d;
  logic [WORD_WIDTH-1:0]   data_q, data_d;

  assign req_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], link.req_toggle};
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  // Only a change of the synchronised level matters; its polarity is never used.
  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    data_d     = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_sync != req_seen_q) begin
          data_d     = link.data_in;
          req_seen_d = req_sync;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (link.ready_in) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign link.ack_toggle = ack_q;
  assign link.valid_out  = valid_q;
  assign link.data_out   = data_q;

endmodule

// File: tb/tb_cdc_2phase_receiver.sv
// Self-checking bench for cdc_2phase_receiver: directed handshake scenarios
// followed by a randomized sender/consumer run checked against a word queue.
module tb_cdc_2phase_receiver;

  localparam int unsigned W      = 8;
  localparam int unsigned STAGES = 2;
  localparam int unsigned NRAND  = 40;

  logic clock = 1'b0;
  logic clear = 1'b0;
  bit   clk_run = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cdc_2phase_receiver_if #(.WORD_WIDTH(W)) link ();

  cdc_2phase_receiver #(
    .WORD_WIDTH (W),
    .SYNC_STAGES(STAGES)
  ) dut (
    .clock(clock),
    .clear(clear),
    .link (link.slave)
  );

  always #5 if (clk_run) clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] rxq[$];
    logic [W-1:0] w;
    logic         exp_ack;
    logic         last_ack;
    int unsigned  toggles, sent, rx, delay;
    bit           outstanding, acc_pend, ready;

    link.req_toggle = 1'b0;
    link.data_in    = '0;
    link.ready_in   = 1'b0;

    // Reset with no clock edges at all
    #1 clear = 1'b1;
    #1;
    check_eq("reset_ack",   link.ack_toggle, 0);
    check_eq("reset_valid", link.valid_out,  0);
    check_eq("reset_data",  link.data_out,   8'h00);
    #3 clear = 1'b0;
    clk_run = 1'b1;
    tick();

    // Single transfer 0xA5, rising request
    link.data_in = 8'hA5; link.req_toggle = 1'b1; link.ready_in = 1'b1;
    for (int i = 0; i < int'(STAGES); i++) begin
      tick();
      check_eq("single_latency_valid", link.valid_out, 0);
    end
    tick();
    check_eq("single_valid", link.valid_out, 1);
    check_eq("single_data",  link.data_out,  8'hA5);
    check_eq("single_ack_before", link.ack_toggle, 0);
    tick();
    check_eq("single_valid_after", link.valid_out, 0);
    check_eq("single_ack_after",   link.ack_toggle, 1);

    // Falling request 0x3C
    link.data_in = 8'h3C; link.req_toggle = 1'b0;
    repeat (STAGES + 1) tick();
    check_eq("fall_valid", link.valid_out, 1);
    check_eq("fall_data",  link.data_out,  8'h3C);
    tick();
    check_eq("fall_ack", link.ack_toggle, 0);
    check_eq("fall_valid_after", link.valid_out, 0);

    // Backpressure with data_in changing during HOLD
    link.ready_in = 1'b0; link.data_in = 8'hA5; link.req_toggle = 1'b1;
    repeat (STAGES + 1) tick();
    check_eq("bp_capture_valid", link.valid_out, 1);
    check_eq("bp_capture_data",  link.data_out,  8'hA5);
    link.data_in = 8'hFF;
    repeat (5) begin
      tick();
      check_eq("bp_hold_valid", link.valid_out,  1);
      check_eq("bp_hold_data",  link.data_out,   8'hA5);
      check_eq("bp_hold_ack",   link.ack_toggle, 0);
    end
    link.ready_in = 1'b1;
    tick();
    check_eq("bp_release_ack",   link.ack_toggle, 1);
    check_eq("bp_release_valid", link.valid_out,  0);

    // Back-to-back: sender re-requests as soon as it sees each ack
    toggles  = 0;
    sent     = 1;
    last_ack = link.ack_toggle;
    link.data_in = 8'h01; link.req_toggle = ~link.req_toggle;
    for (int c = 0; c < 100 && toggles < 4; c++) begin
      tick();
      if (link.valid_out) rxq.push_back(link.data_out);
      if (link.ack_toggle != last_ack) begin
        toggles++;
        last_ack = link.ack_toggle;
        if (sent < 4) begin
          sent++;
          link.data_in = W'(sent);
          link.req_toggle = ~link.req_toggle;
        end
      end
    end
    repeat (6) begin
      tick();
      if (link.valid_out) rxq.push_back(link.data_out);
      if (link.ack_toggle != last_ack) begin toggles++; last_ack = link.ack_toggle; end
    end
    check_eq("b2b_ack_toggles", toggles, 4);
    check_eq("b2b_word_count", rxq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = (rxq.size() != 0) ? rxq.pop_front() : 8'hXX;
      check_eq("b2b_word", w, i + 1);
    end
    exp_ack = 1'b1;
    check_eq("b2b_ack_level", link.ack_toggle, exp_ack);

    // Randomized sender delays and consumer stalls against a word queue
    sent = 0; rx = 0; delay = 0; outstanding = 0; acc_pend = 0;
    last_ack = link.ack_toggle;
    link.ready_in = 1'b0;
    for (int c = 0; c < 6000 && rx < NRAND; c++) begin
      tick();
      if (acc_pend) begin exp_ack = ~exp_ack; acc_pend = 0; end
      check_eq("rand_ack", link.ack_toggle, exp_ack);
      if (link.valid_out) check_eq("rand_valid_has_word", q.size() != 0, 1);
      if (outstanding && link.ack_toggle != last_ack) begin
        outstanding = 0;
        delay = $urandom_range(0, 3);
      end
      last_ack = link.ack_toggle;
      if (!outstanding && sent < NRAND) begin
        if (delay == 0) begin
          w = W'($urandom);
          link.data_in = w;
          link.req_toggle = ~link.req_toggle;
          q.push_back(w);
          sent++;
          outstanding = 1;
        end else begin
          delay--;
        end
      end
      ready = ($urandom_range(0, 3) != 0);
      link.ready_in = ready;
      if (link.valid_out && ready && q.size() != 0) begin
        check_eq("rand_data", link.data_out, q.pop_front());
        rx++;
        acc_pend = 1;
      end
    end
    tick();
    if (acc_pend) exp_ack = ~exp_ack;
    check_eq("rand_final_ack", link.ack_toggle, exp_ack);
    check_eq("rand_words_received", rx, NRAND);
    check_eq("rand_final_valid", link.valid_out, 0);

    // Reset in HOLD discards the word and the ack
    link.ready_in = 1'b0; link.data_in = 8'h5A; link.req_toggle = ~link.req_toggle;
    repeat (STAGES + 1) tick();
    check_eq("midrst_hold_valid", link.valid_out, 1);
    check_eq("midrst_hold_data",  link.data_out,  8'h5A);
    #2 clear = 1'b1;
    #1;
    check_eq("midrst_valid", link.valid_out,  0);
    check_eq("midrst_data",  link.data_out,   8'h00);
    check_eq("midrst_ack",   link.ack_toggle, 0);
    link.req_toggle = 1'b0;
    #1 clear = 1'b0;
    link.ready_in = 1'b1;
    repeat (6) begin
      tick();
      check_eq("midrst_no_spurious_valid", link.valid_out,  0);
      check_eq("midrst_ack_stays",         link.ack_toggle, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
